// File: rtl/pile_pkg.sv
// Shared defaults and the counter action encoding for the brick-stack tracker.
package pile_pkg;

   localparam int WIDTH_DEF      = 3;
   localparam int MAX_HEIGHT_DEF = 7;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_INC  = 2'd1,
      ACT_DEC  = 2'd2,
      ACT_ERR  = 2'd3
   } action_e;

endpackage

// File: rtl/pile_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector giving one pulse per 0->1 transition.
module pile_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic in_async,
   output logic pulse
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour, which is what makes this a shift chain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= in_async;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // prev_q clears at reset, so a level already high at release counts as a new edge.
   assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/pile.sv
// Brick-stack height tracker: saturating up/down counter driven by
// synchronised, edge-detected plus/moins button presses.
module pile
   import pile_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int MAX_HEIGHT = MAX_HEIGHT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             plus,
   input  logic             moins,
   output logic [WIDTH-1:0] Hauteur,
   output logic             vide,
   output logic             pleine,
   output logic             erreur
);

   localparam logic [WIDTH-1:0] MAX_H = WIDTH'(MAX_HEIGHT);

   logic             p_pulse;
   logic             m_pulse;
   action_e          action;
   logic [WIDTH-1:0] hauteur_d, hauteur_q;
   logic             vide_d, vide_q;
   logic             pleine_d, pleine_q;
   logic             erreur_d, erreur_q;

   pile_sync_edge u_sync_plus (
      .clk      (clk),
      .reset    (reset),
      .in_async (plus),
      .pulse    (p_pulse)
   );

   pile_sync_edge u_sync_moins (
      .clk      (clk),
      .reset    (reset),
      .in_async (moins),
      .pulse    (m_pulse)
   );

   // Simultaneous add and remove cancel out and fall through to ACT_HOLD.
   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      action = ACT_HOLD;
      if (p_pulse && !m_pulse) begin
         action = (hauteur_q == MAX_H) ? ACT_ERR : ACT_INC;
      end else if (m_pulse && !p_pulse) begin
         action = (hauteur_q == '0) ? ACT_ERR : ACT_DEC;
      end
   end

   always_comb begin
      hauteur_d = hauteur_q;
      erreur_d  = 1'b0;
      unique case (action)
         ACT_INC: hauteur_d = hauteur_q + WIDTH'(1);
         ACT_DEC: hauteur_d = hauteur_q - WIDTH'(1);
         ACT_ERR: erreur_d  = 1'b1;
         default: ;
      endcase
      vide_d   = (hauteur_d == '0);
      pleine_d = (hauteur_d == MAX_H);
   end

   // Flags are derived from the next height so they flip on the same edge as Hauteur.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hauteur_q <= '0;
         vide_q    <= 1'b1;
         pleine_q  <= 1'b0;
         erreur_q  <= 1'b0;
      end else begin
         hauteur_q <= hauteur_d;
         vide_q    <= vide_d;
         pleine_q  <= pleine_d;
         erreur_q  <= erreur_d;
      end
   end

   assign Hauteur = hauteur_q;
   assign vide    = vide_q;
   assign pleine  = pleine_q;
   assign erreur  = erreur_q;

endmodule

// File: tb/tb_pile.sv
// Self-checking bench for pile: directed scenarios plus random button activity,
// compared every cycle against a sample-history reference model.
module tb_pile;
   import pile_pkg::*;

   localparam int W    = WIDTH_DEF;
   localparam int MAXH = MAX_HEIGHT_DEF;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         plus  = 1'b0;
   logic         moins = 1'b0;
   logic [W-1:0] Hauteur;
   logic         vide;
   logic         pleine;
   logic         erreur;

   int n_checks = 0;
   int n_errors = 0;
   int err_seen = 0;

   // Reference model: input levels seen at each edge; an event lands two edges
   // after the first edge that sees the level high, if the edge before saw it low.
   logic [2:0] hp    = '0;
   logic [2:0] hm    = '0;
   int         m_h   = 0;
   bit         m_err = 1'b0;
   logic       ev_p, ev_m;

   assign ev_p = hp[1] & ~hp[2];
   assign ev_m = hm[1] & ~hm[2];

   always #10 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         hp    <= '0;
         hm    <= '0;
         m_h   <= 0;
         m_err <= 1'b0;
      end else begin
         hp    <= {hp[1:0], plus};
         hm    <= {hm[1:0], moins};
         m_err <= 1'b0;
         if (ev_p && !ev_m) begin
            if (m_h < MAXH) m_h <= m_h + 1;
            else            m_err <= 1'b1;
         end else if (ev_m && !ev_p) begin
            if (m_h > 0) m_h <= m_h - 1;
            else         m_err <= 1'b1;
         end
      end
   end

   pile #(.WIDTH(W), .MAX_HEIGHT(MAXH)) dut (
      .clk     (clk),
      .reset   (reset),
      .plus    (plus),
      .moins   (moins),
      .Hauteur (Hauteur),
      .vide    (vide),
      .pleine  (pleine),
      .erreur  (erreur)
   );

   task automatic check(input string tag, input int obs, input int exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check("model_hauteur", int'(Hauteur), m_h);
      check("model_vide",    int'(vide),    int'(m_h == 0));
      check("model_pleine",  int'(pleine),  int'(m_h == MAXH));
      check("model_erreur",  int'(erreur),  int'(m_err));
      if (erreur) err_seen++;
   endtask

   task automatic press(input logic p, input logic m);
      plus  = p;
      moins = m;
      tick();
      tick();
      plus  = 1'b0;
      moins = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #1 reset = 1'b0;
      #100;
      @(negedge clk);
      check("rst_hauteur", int'(Hauteur), 0);
      check("rst_vide",    int'(vide),    1);
      check("rst_pleine",  int'(pleine),  0);
      check("rst_erreur",  int'(erreur),  0);
      reset = 1'b1;
      repeat (5) tick();
      check("idle_hauteur", int'(Hauteur), 0);

      // Held press: exactly one increment, visible on the third edge.
      plus = 1'b1;
      tick();
      check("lat_e1", int'(Hauteur), 0);
      tick();
      check("lat_e2", int'(Hauteur), 0);
      tick();
      check("lat_e3", int'(Hauteur), 1);
      check("lat_vide", int'(vide), 0);
      tick();
      tick();
      check("held_once", int'(Hauteur), 1);
      plus = 1'b0;
      repeat (3) tick();

      err_seen = 0;
      moins = 1'b1;
      repeat (5) tick();
      moins = 1'b0;
      repeat (2) tick();
      check("rm_hauteur", int'(Hauteur), 0);
      check("rm_vide",    int'(vide),    1);
      check("rm_no_err",  err_seen,      0);

      err_seen = 0;
      press(1'b1, 1'b1);
      check("both_at0_h",   int'(Hauteur), 0);
      check("both_at0_err", err_seen,      0);
      repeat (3) press(1'b1, 1'b0);
      check("three", int'(Hauteur), 3);
      press(1'b1, 1'b1);
      check("both_at3_h",   int'(Hauteur), 3);
      check("both_at3_err", err_seen,      0);

      repeat (3) press(1'b0, 1'b1);
      err_seen = 0;
      repeat (8) press(1'b1, 1'b0);
      check("full_h",      int'(Hauteur), MAXH);
      check("full_pleine", int'(pleine),  1);
      check("full_err",    err_seen,      1);

      repeat (7) press(1'b0, 1'b1);
      err_seen = 0;
      press(1'b0, 1'b1);
      check("empty_h",   int'(Hauteur), 0);
      check("empty_err", err_seen,      1);

      // Async reset between edges, with a plus press still in the synchroniser.
      repeat (5) press(1'b1, 1'b0);
      check("five", int'(Hauteur), 5);
      plus = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("arst_hauteur", int'(Hauteur), 0);
      check("arst_vide",    int'(vide),    1);
      check("arst_pleine",  int'(pleine),  0);
      @(negedge clk);
      tick();
      err_seen = 0;
      reset = 1'b1;
      repeat (6) tick();
      check("rel_held_h",   int'(Hauteur), 1);
      check("rel_held_err", err_seen,      0);
      plus = 1'b0;
      repeat (3) tick();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) plus  = ~plus;
         if ($urandom_range(0, 2) == 0) moins = ~moins;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
